// File: rtl/ghost_sprite_renderer.sv
// ============================================================================
// ghost_sprite_renderer : per-pixel colour index for one tile-aligned ghost
// Revision: 1.0
// ============================================================================
`default_nettype none

module ghost_sprite_renderer #(
  parameter logic [2:0] BODY_COLOR  = 3'd4,
  parameter logic [2:0] EYE_COLOR   = 3'd7,
  parameter logic [2:0] PUPIL_COLOR = 3'd1,
  parameter int         ANIM_DIV    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic [9:0] shpos,
  input  logic [9:0] svpos,
  input  logic [1:0] direction,
  input  logic [4:0] xpos,
  input  logic [4:0] ypos,
  output logic [2:0] col
);

  localparam logic [7:0] C_ANIM_LAST = 8'(ANIM_DIV - 1);
  localparam logic [4:0] C_TILE_LIMIT = 5'd30;

  logic [2:0] col_q, col_d;
  logic       frame_q, frame_d;
  logic [7:0] anim_cnt_q, anim_cnt_d;

  logic [2:0] w_c, w_r;
  logic       w_hit;
  logic [7:0] w_row_bits;
  logic       w_body_bit;
  logic       w_eye_region;
  logic       w_left_col;
  logic       w_pupil;

  assign w_c = shpos[3:1];
  assign w_r = svpos[3:1];

  // Tiles 30/31 fall outside the 480-pixel playfield and must never draw.
  assign w_hit = !shpos[9] && (shpos[8:4] == xpos) &&
                 !svpos[9] && (svpos[8:4] == ypos) &&
                 (xpos < C_TILE_LIMIT) && (ypos < C_TILE_LIMIT);

  always_comb begin
    w_row_bits = 8'b1111_1111;
    case (w_r)
      3'd0:    w_row_bits = 8'b0011_1100;
      3'd1:    w_row_bits = 8'b0111_1110;
      3'd7:    w_row_bits = frame_q ? 8'b0110_1101 : 8'b1101_1011;
      default: w_row_bits = 8'b1111_1111;
    endcase
  end

  // Column 0 is the bitmap MSB.
  assign w_body_bit = w_row_bits[3'd7 - w_c];

  assign w_eye_region = ((w_r == 3'd2) || (w_r == 3'd3)) &&
                        ((w_c == 3'd1) || (w_c == 3'd2) ||
                         (w_c == 3'd5) || (w_c == 3'd6));
  assign w_left_col   = (w_c == 3'd1) || (w_c == 3'd5);

  always_comb begin
    w_pupil = 1'b0;
    case (direction)
      2'd0: w_pupil = (w_r == 3'd2);
      2'd1: w_pupil = w_left_col;
      2'd2: w_pupil = (w_r == 3'd3);
      2'd3: w_pupil = !w_left_col;
      default: w_pupil = 1'b0;
    endcase
  end

  always_comb begin
    col_d = 3'd0;
    if (w_hit) begin
      if (w_eye_region)
        col_d = w_pupil ? PUPIL_COLOR : EYE_COLOR;
      else if (w_body_bit)
        col_d = BODY_COLOR;
    end
  end

  always_comb begin
    anim_cnt_d = anim_cnt_q;
    frame_d    = frame_q;
    if (ce) begin
      if (anim_cnt_q == C_ANIM_LAST) begin
        anim_cnt_d = 8'd0;
        frame_d    = !frame_q;
      end else begin
        anim_cnt_d = anim_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q      <= 3'd0;
      frame_q    <= 1'b0;
      anim_cnt_q <= 8'd0;
    end else begin
      col_q      <= col_d;
      frame_q    <= frame_d;
      anim_cnt_q <= anim_cnt_d;
    end
  end

  assign col = col_q;

endmodule

`default_nettype wire

// File: tb/tb_ghost_sprite_renderer.sv
// ============================================================================
// tb_ghost_sprite_renderer : directed vector bench for ghost_sprite_renderer
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ghost_sprite_renderer;

  logic       clk;
  logic       reset;
  logic       ce;
  logic [9:0] shpos;
  logic [9:0] svpos;
  logic [1:0] direction;
  logic [4:0] xpos;
  logic [4:0] ypos;
  logic [2:0] col;

  int tests_run;
  int tests_failed;

  typedef struct {
    string      name;
    logic [9:0] sh;
    logic [9:0] sv;
    logic [1:0] dir;
    logic [4:0] x;
    logic [4:0] y;
    logic [2:0] exp_col;
  } vec_t;

  vec_t vecs[$];

  ghost_sprite_renderer dut (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .shpos     (shpos),
    .svpos     (svpos),
    .direction (direction),
    .xpos      (xpos),
    .ypos      (ypos),
    .col       (col)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp_v);
    tests_run++;
    if (act !== exp_v) begin
      tests_failed++;
      $display("FAIL %s: col=%0d expected=%0d", name, act, exp_v);
    end
  endtask

  task automatic drive(input logic [9:0] sh, input logic [9:0] sv, input logic [1:0] dir,
                       input logic [4:0] x, input logic [4:0] y);
    @(negedge clk);
    shpos     = sh;
    svpos     = sv;
    direction = dir;
    xpos      = x;
    ypos      = y;
  endtask

  task automatic ce_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ce = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    ce = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset = 1'b0;
    ce    = 1'b0;
    shpos = 10'd0; svpos = 10'd0; direction = 2'd0; xpos = 5'd0; ypos = 5'd0;

    vecs.push_back('{"r0c0_transparent", 10'd0,   10'd0,  2'd0, 5'd0,  5'd0,  3'd0});
    vecs.push_back('{"body_c3_r4",       10'd54,  10'd40, 2'd0, 5'd3,  5'd2,  3'd4});
    vecs.push_back('{"left_of_tile",     10'd47,  10'd40, 2'd0, 5'd3,  5'd2,  3'd0});
    vecs.push_back('{"r0c0_tile3_2",     10'd48,  10'd32, 2'd0, 5'd3,  5'd2,  3'd0});
    vecs.push_back('{"r0c3_body",        10'd54,  10'd32, 2'd0, 5'd3,  5'd2,  3'd4});
    vecs.push_back('{"eye_up_c1r2",      10'd2,   10'd4,  2'd0, 5'd0,  5'd0,  3'd1});
    vecs.push_back('{"eye_down_c1r2",    10'd2,   10'd4,  2'd2, 5'd0,  5'd0,  3'd7});
    vecs.push_back('{"eye_left_c1r2",    10'd2,   10'd4,  2'd1, 5'd0,  5'd0,  3'd1});
    vecs.push_back('{"eye_right_c1r2",   10'd2,   10'd4,  2'd3, 5'd0,  5'd0,  3'd7});
    vecs.push_back('{"eye_right_c2r2",   10'd4,   10'd4,  2'd3, 5'd0,  5'd0,  3'd1});
    vecs.push_back('{"eye_up_c6r3",      10'd12,  10'd6,  2'd0, 5'd0,  5'd0,  3'd7});
    vecs.push_back('{"eye_left_c6r3",    10'd12,  10'd6,  2'd1, 5'd0,  5'd0,  3'd7});
    vecs.push_back('{"eye_right_c6r3",   10'd12,  10'd6,  2'd3, 5'd0,  5'd0,  3'd1});
    vecs.push_back('{"eye_down_c5r3",    10'd10,  10'd6,  2'd2, 5'd0,  5'd0,  3'd1});
    vecs.push_back('{"body_c5r6",        10'd10,  10'd12, 2'd0, 5'd0,  5'd0,  3'd4});
    vecs.push_back('{"r1c0_transparent", 10'd0,   10'd2,  2'd0, 5'd0,  5'd0,  3'd0});
    vecs.push_back('{"r1c1_body",        10'd2,   10'd2,  2'd0, 5'd0,  5'd0,  3'd4});
    vecs.push_back('{"xpos30_offfield",  10'd486, 10'd40, 2'd0, 5'd30, 5'd2,  3'd0});
    vecs.push_back('{"shpos9_set",       10'd566, 10'd40, 2'd0, 5'd3,  5'd2,  3'd0});
    vecs.push_back('{"ypos30_offfield",  10'd54,  10'd488,2'd0, 5'd3,  5'd30, 3'd0});
    vecs.push_back('{"body_tile29",      10'd470, 10'd472,2'd0, 5'd29, 5'd29, 3'd4});

    #12;
    check("reset_held_col", col, 3'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("after_release", col, 3'd0);

    // Table of independent one-cycle vectors (frame 0, ce idle).
    foreach (vecs[i]) begin
      drive(vecs[i].sh, vecs[i].sv, vecs[i].dir, vecs[i].x, vecs[i].y);
      @(posedge clk);
      #1;
      check(vecs[i].name, col, vecs[i].exp_col);
    end

    // Animation at r7 c2: frame 0 bit clear, frame 1 bit set.
    drive(10'd4, 10'd14, 2'd0, 5'd0, 5'd0);
    @(posedge clk);
    #1;
    check("anim_initial", col, 3'd0);
    ce_pulses(8);
    check("anim_after_8", col, 3'd4);
    ce_pulses(8);
    check("anim_after_16", col, 3'd0);
    ce_pulses(7);
    check("anim_after_7_only", col, 3'd0);
    ce_pulses(1);
    check("anim_8th_pulse", col, 3'd4);

    // Mid-count asynchronous reset must clear col and discard the partial count.
    ce_pulses(5);
    check("pre_reset_col", col, 3'd4);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_col", col, 3'd0);
    @(negedge clk);
    reset = 1'b1;
    ce_pulses(7);
    check("reset_discards_count", col, 3'd0);
    ce_pulses(1);
    check("post_reset_toggle", col, 3'd4);

    // Latency: xpos alternates each cycle; col lags by exactly one cycle.
    ce_pulses(8);
    begin
      logic [2:0] prev_exp;
      prev_exp = 3'd0;
      drive(10'd54, 10'd40, 2'd0, 5'd4, 5'd2);
      @(posedge clk);
      #1;
      for (int i = 0; i < 6; i++) begin
        logic [4:0] xv;
        logic [2:0] e;
        xv = (i % 2 == 0) ? 5'd3 : 5'd4;
        e  = (i % 2 == 0) ? 3'd4 : 3'd0;
        drive(10'd54, 10'd40, 2'd0, xv, 5'd2);
        #1;
        check("latency_hold", col, prev_exp);
        @(posedge clk);
        #1;
        check("latency_update", col, e);
        prev_exp = e;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ghost_sprite_renderer.md
# ghost_sprite_renderer

Per-pixel renderer for one tile-aligned ghost sprite (Blinky) in the 480x480 maze playfield. It compares the beam position against the ghost's tile coordinates and outputs a 3-bit colour index, 0 meaning transparent. The colour mixer combines that index with the grid and Pac-Man layers. The block also provides a two-frame skirt animation advanced by the access-manager enable `ce`, and eye pupils that follow the ghost's direction.

## Interface
- `BODY_COLOR`, default 3'd4: colour index of the body.
- `EYE_COLOR`, default 3'd7: colour index of the eye whites.
- `PUPIL_COLOR`, default 3'd1: colour index of the pupils.
- `ANIM_DIV`, default 8: number of `ce` pulses per animation-frame toggle; range 1..256.
- `clk` in 1: system/pixel clock. There is one clock; everything is on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `ce` in 1: animation-advance enable from the access manager.
- `shpos` in 10: beam horizontal position.
- `svpos` in 10: beam vertical position.
- `direction` in 2: 0=up, 1=left, 2=down, 3=right.
- `xpos` in 5: ghost tile column.
- `ypos` in 5: ghost tile row.
- `col` out 3: registered colour index for the pixel; 0 = transparent.

## Operation
- **Geometry:**
  - A tile is 16x16 screen pixels.
  - The sprite is an 8x8 bitmap with each bitmap pixel doubled to a 2x2 block.
  - Local column `c = shpos[3:1]`, local row `r = svpos[3:1]`. Column 0 is the left edge, row 0 the top.
- **Hit condition:** all of the following must hold.
  - `shpos[9] == 0` and `shpos[8:4] == xpos`.
  - `svpos[9] == 0` and `svpos[8:4] == ypos`.
  - `xpos < 30` and `ypos < 30`. Tiles 30/31 lie outside the playfield, so those positions never draw.
- **Body bitmap** (row: bits with column 0 as MSB):
  - r0 `00111100`
  - r1 `01111110`
  - r2..r6 `11111111`
  - r7 frame 0 `11011011`
  - r7 frame 1 `01101101`
- **Eye regions:** rows 2-3 × columns {1,2} and rows 2-3 × columns {5,6}. Within each 2x2 eye:
  - Up (0): row 2 is pupil, row 3 is white.
  - Down (2): row 3 is pupil, row 2 is white.
  - Left (1): left column (1 or 5) is pupil, right column is white.
  - Right (3): right column (2 or 6) is pupil, left column is white.
- **Colour priority:**
  1. No hit → 0.
  2. Eye-region pupil pixel → `PUPIL_COLOR`.
  3. Eye-region white pixel → `EYE_COLOR`.
  4. Body bit set → `BODY_COLOR`.
  5. Otherwise → 0.
- **Animation:**
  - An 8-bit counter `anim_cnt` increments on each clock with `ce=1`.
  - When the counter reaches `ANIM_DIV-1` with `ce=1`, it clears to 0 and `frame` toggles.
  - With `ANIM_DIV=1`, every `ce` pulse toggles `frame`.
  - `ce` held high counts every clock.
- **Input sampling:** `direction`, `xpos` and `ypos` are used combinationally and sampled in the same cycle as the beam position. A change takes effect on the next pixel, with no frame buffering.

## Timing
- `col` is registered, with 1-cycle latency: `col` at edge n+1 reflects `shpos`/`svpos`/`direction`/`xpos`/`ypos`/`frame` sampled at edge n.
- The `frame` toggle is visible in `col` on the cycle after the toggle edge.
- Reset (asynchronous, `reset=0`):
  - `col=0`, `frame=0`, `anim_cnt=0` immediately.
  - Held while low.
  - Normal operation resumes on the first rising edge after release.
- Reset mid-animation discards the partial count.
- `ce` asserted in the same cycle as reset release is ignored.
- No handshake; the block never stalls.

## Test plan
- **Reset:** assert `reset=0` mid-frame → `col=0` asynchronously. Release, drive beam (0,0) with `xpos=ypos=0` → `col=0` (r0 c0 is transparent).
- **Body/edge:** `xpos=3`, `ypos=2`.
  - `shpos=54`, `svpos=40` (c3, r4) → `col=4` one cycle later.
  - `shpos=47` → `col=0`.
  - `shpos=48`, `svpos=32` (c0, r0) → `col=0`.
  - `shpos=54`, `svpos=32` (c3, r0) → `col=4`.
- **Eyes:** tile (0,0), `svpos=4` (r2), `shpos=2` (c1):
  - `direction=0` → 1.
  - `direction=2` → 7.
  - `direction=1` → 1.
  - `direction=3` → 7.
  - With `direction=3` and `shpos=4` (c2) → 1.
- **Animation:** tile (0,0), `svpos=14` (r7), `shpos=4` (c2).
  - Initially `col=0` (frame 0, bit 0).
  - After 8 `ce` pulses → `col=4`.
  - After 8 more → `col=0`.
  - After 7 pulses only → unchanged.
- **Off-field:** `xpos=30` with beam at `shpos=486`, `svpos=40` → `col=0`. Also `shpos=512+54` with `xpos=3` → `col=0`.
- **Latency:** toggle `xpos` between 3 and 4 every cycle while `shpos=54`, `svpos=40`. `col` alternates 4/0, lagging the input by exactly one cycle.
